// File: rtl/fpu_minmax_reduce_ctrl.sv
// ---------------------------------------------------------------------------
// fpu_minmax_reduce_ctrl
//
// Reduces a stream of LEN single-precision operands to a single min or max
// value. It does this by sequencing an external, shared, combinational FP32
// min/max comparator and keeping the running result in an accumulator.
// The controller does no floating-point arithmetic of its own. NaN handling,
// tie-breaking and signed-zero ordering all come from the comparator.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   start, mode, len    job request; sampled only in IDLE
//                       (mode 1 = fmax, 0 = fmin)
//   in_valid/in_ready   operand handshake; in_data carries the FP32 operand
//   cmp_a/cmp_b/cmp_mode
//                       comparator drive (accumulator, operand, latched mode)
//   cmp_answer          comparator result, used combinationally
//   out_valid/out_ready result handshake; out_data carries the reduced value
//   busy                high whenever a job is in progress
// ---------------------------------------------------------------------------
module fpu_minmax_reduce_ctrl #(
    parameter int          LEN_W = 8,
    parameter logic [31:0] QNAN  = 32'hFFC00000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic [31:0]      cmp_a,
    output logic [31:0]      cmp_b,
    output logic             cmp_mode,
    input  logic [31:0]      cmp_answer,
    output logic             out_valid,
    output logic [31:0]      out_data,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FIRST = 2'd1,
        S_ACCUM = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] CNT_ZERO = '0;

    state_t           state_reg, state_next;
    logic [31:0]      acc_reg, acc_next;
    logic [LEN_W-1:0] cnt_reg, cnt_next;
    logic             mode_reg, mode_next;

    logic [LEN_W-1:0] cnt_dec;
    logic             take_op;

    // Saturating decrement. This keeps the counter from wrapping even if an
    // operand were ever accepted with the count already at zero.
    assign cnt_dec = (cnt_reg != CNT_ZERO) ? (cnt_reg - CNT_ONE) : cnt_reg;

    // in_ready comes only from the registered state, so it never depends on
    // in_valid.
    assign in_ready  = (state_reg == S_FIRST) || (state_reg == S_ACCUM);
    assign take_op   = in_valid && in_ready;
    assign out_valid = (state_reg == S_DONE);
    assign out_data  = (state_reg == S_DONE) ? acc_reg : 32'h0;
    assign busy      = (state_reg != S_IDLE);

    assign cmp_a    = acc_reg;
    assign cmp_b    = in_data;
    assign cmp_mode = mode_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            acc_reg   <= 32'h0;
            cnt_reg   <= '0;
            mode_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            mode_reg  <= mode_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        mode_next  = mode_reg;

        unique case (state_reg)
            S_IDLE: begin
                if (start) begin
                    mode_next = mode;
                    cnt_next  = len;
                    if (len == CNT_ZERO) begin
                        // An empty job still produces a result, namely the
                        // comparator's canonical NaN.
                        acc_next   = QNAN;
                        state_next = S_DONE;
                    end else begin
                        state_next = S_FIRST;
                    end
                end
            end
            S_FIRST: begin
                // The first operand seeds the accumulator directly. Comparing
                // it against the stale accumulator would give a wrong result.
                if (take_op) begin
                    acc_next   = in_data;
                    cnt_next   = cnt_dec;
                    state_next = (cnt_dec == CNT_ZERO) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (take_op) begin
                    acc_next = cmp_answer;
                    cnt_next = cnt_dec;
                    if (cnt_dec == CNT_ZERO) begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule
